// File: rtl/pm_flow_pkg.sv
// Shared opcode constants and FSM state encoding for the fetch-side flow controller.
package pm_flow_pkg;

  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_CALL = 6'h03;
  localparam logic [5:0] OP_RET  = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pm_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry
// and raises wrap; top is the most recent entry, read combinationally.
module pm_ras
  import pm_flow_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         wrap
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     entry_reg [DEPTH];

  assign top_idx = ptr_reg - PTR_W'(1);
  assign top     = entry_reg[top_idx];
  assign empty   = (cnt_reg == '0);
  assign full    = (cnt_reg == CNT_W'(DEPTH));
  assign wrap    = push & full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (push) begin
      entry_reg[ptr_reg] <= push_data;
      ptr_reg            <= ptr_reg + PTR_W'(1);
      // Depth saturates: a wrapping push replaces the oldest entry instead.
      if (!full) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr_reg <= top_idx;
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pm_flow_ctrl.sv
// Fetch flow controller: decodes JMP/CALL/RET/HALT, squashes wrong-path fetches
// and holds fetch on HALT or hazard. Optional counters under PM_FLOW_PERF_EN.
module pm_flow_ctrl
  import pm_flow_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic [ADDR_W-1:0] current_address,
  input  logic              ex_stall_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              stall,
  output logic              stall_pm,
  output logic              ins_kill,
  output logic              halted,
`ifdef PM_FLOW_PERF_EN
  output logic              ras_err,
  output logic [15:0]       redirect_cnt,
  output logic [15:0]       stall_cnt
`else
  output logic              ras_err
`endif
);

  state_t            state_reg, state_next;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic              ras_push, ras_pop, ras_underflow;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_wrap;
  logic              unused_ras_full;
  logic              unused_ins;
  logic              ras_err_reg;

  assign opcode     = ins[31:26];
  assign target     = ins[ADDR_W-1:0];
  assign unused_ins = ^ins;

  pm_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (current_address + ADDR_W'(1)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full),
    .wrap      (ras_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= RUN;
      ras_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ras_err_reg <= ras_err_reg | ras_underflow | ras_wrap;
    end
  end

  // Outputs are forced idle while reset is held so nothing leaks from ins.
  always_comb begin
    state_next    = state_reg;
    pc_mux_sel    = 1'b0;
    jmp_loc       = '0;
    stall         = 1'b0;
    ins_kill      = 1'b0;
    halted        = 1'b0;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ras_underflow = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (ex_stall_req) begin
            stall = 1'b1;
          end else begin
            case (opcode)
              OP_JMP: begin
                pc_mux_sel = 1'b1;
                jmp_loc    = target;
                state_next = FLUSH;
              end
              OP_CALL: begin
                pc_mux_sel = 1'b1;
                jmp_loc    = target;
                ras_push   = 1'b1;
                state_next = FLUSH;
              end
              OP_RET: begin
                if (ras_empty) begin
                  ras_underflow = 1'b1;
                end else begin
                  pc_mux_sel = 1'b1;
                  jmp_loc    = ras_top;
                  ras_pop    = 1'b1;
                  state_next = FLUSH;
                end
              end
              OP_HALT: begin
                stall      = 1'b1;
                state_next = HALT;
              end
              default: ;
            endcase
          end
        end
        FLUSH: begin
          ins_kill = 1'b1;
          if (ex_stall_req) begin
            stall = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
        HALT: begin
          halted = 1'b1;
          stall  = 1'b1;
          // Releasing stall on the resume cycle lets the PC step past the HALT.
          if (resume && !ex_stall_req) begin
            stall      = 1'b0;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign stall_pm = stall;
  assign ras_err  = ras_err_reg;

`ifdef PM_FLOW_PERF_EN
  logic [15:0] redirect_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt_reg <= '0;
      stall_cnt_reg    <= '0;
    end else begin
      if (pc_mux_sel && redirect_cnt_reg != 16'hFFFF) begin
        redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
      end
      if (stall && stall_cnt_reg != 16'hFFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_reg;
  assign stall_cnt    = stall_cnt_reg;
`endif

endmodule

// File: doc/pm_flow_ctrl.md
Name: pm_flow_ctrl

Overview:
Fetch-side flow controller that consumes the instruction stream coming out of the program memory block. It receives ins and current_address and drives that block's control inputs: jmp_loc, pc_mux_sel, stall and stall_pm. It decodes JMP/CALL/RET/HALT, keeps a small return-address stack, squashes the wrong-path instruction after every redirect, and holds fetch on HALT or on an external hazard request. It sits between program memory and the decode stage.

Parameters:
RAS_DEPTH, 4, number of return-address stack entries (power of two, 2..16)
ADDR_W, 16, program address width; matches current_address/jmp_loc

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ins  input  32  instruction fetched from program memory
current_address  input  ADDR_W  address of ins
ex_stall_req  input  1  downstream hazard; hold fetch this cycle
resume  input  1  one-cycle pulse; leave HALT
jmp_loc  output  ADDR_W  redirect target to program memory
pc_mux_sel  output  1  1 = PC loads jmp_loc at next edge; 0 = sequential
stall  output  1  1 = PC holds
stall_pm  output  1  1 = program-memory output register holds ins
ins_kill  output  1  1 = present ins is wrong-path; decode must treat it as NOP
halted  output  1  1 while in HALT state
ras_err  output  1  sticky RAS overflow/underflow flag; cleared only by reset

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). On assertion: state=RUN, RAS pointer=0, all RAS entries 0, ras_err=0. All outputs 0, including jmp_loc=0.
- Decode: opcode=ins[31:26]; target=ins[ADDR_W-1:0]. Unknown opcodes are sequential.
- FSM states RUN, FLUSH, HALT. Decode is acted on only in RUN with ex_stall_req=0.
- RUN, JMP: pc_mux_sel=1 and jmp_loc=target, both combinational in the same cycle. Next state is FLUSH.
- RUN, CALL: redirect as JMP. Push current_address+1 (mod 2^ADDR_W) at the clock edge. Next state is FLUSH.
- RUN, RET with RAS non-empty: pc_mux_sel=1, jmp_loc=top entry. Pop at the edge. Next state is FLUSH.
- RUN, RET with RAS empty: no redirect and no pop. ras_err set. Remain in RUN (the RET acts as NOP).
- CALL with RAS full: the push overwrites the oldest entry (circular pointer wrap). ras_err set. The redirect still happens.
- RUN, HALT: stall=1 and stall_pm=1 from the same cycle. Next state is HALT.
- FLUSH: lasts exactly 1 cycle. ins_kill=1 and decode is ignored. Next state is RUN.
- FLUSH with ex_stall_req=1: stall and stall_pm assert, and FLUSH is held (ins_kill stays 1) until ex_stall_req drops.
- HALT: halted=1, stall=1, stall_pm=1, pc_mux_sel=0. On resume=1 the next state is RUN. The halted instruction is not re-decoded; stall is released so the PC advances.
- ex_stall_req=1 in RUN: stall=1, stall_pm=1, pc_mux_sel=0, no push/pop, state unchanged. The held ins is decoded once ex_stall_req drops.
- Priority: reset > ex_stall_req > state/decode. resume outside HALT is ignored.
- Reset asserted mid-FLUSH or mid-HALT: immediate return to RUN with cleared RAS.
- stall and stall_pm are identical in this block; they are separate ports only to match the program memory interface.

Optional Feature:
PM_FLOW_PERF_EN
- Defined: adds output ports redirect_cnt[15:0] and stall_cnt[15:0], both reset to 0.
- redirect_cnt counts cycles with pc_mux_sel=1.
- stall_cnt counts cycles with stall=1.
- Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package pm_flow_pkg holds opcode constants OP_JMP=6'h02, OP_CALL=6'h03, OP_RET=6'h04, OP_HALT=6'h3F, and the state encodings RUN/FLUSH/HALT.
- One sub-module, pm_ras: a RAS_DEPTH-entry circular stack with push/pop/top/empty/full/wrap flags.
- The FSM and output logic stay in pm_flow_ctrl.

Test Plan:
- Reset pulse, then ins=NOP stream -> all outputs 0, pc_mux_sel=0 every cycle, ras_err=0.
- ins={OP_JMP,10'b0,16'h0008} at addr 0x0003 -> same cycle pc_mux_sel=1, jmp_loc=0x0008; next cycle ins_kill=1; following cycle ins_kill=0.
- CALL 0x0020 at 0x0005, later RET -> RET cycle jmp_loc=0x0006, pc_mux_sel=1, ras_err=0.
- 5 CALLs (depth 4), then 5 RETs -> ras_err=1 after the 5th CALL. RETs return 0x..(call5+1), call4+1, call3+1, call2+1, then the 5th RET gives no redirect.
- HALT at 0x0009 -> stall=stall_pm=halted=1 held for 10 cycles with no redirect; resume pulse -> next cycle halted=0, stall=0.
- JMP presented with ex_stall_req=1 for 3 cycles -> stall=1, pc_mux_sel=0 for those cycles; redirect to target on the first cycle ex_stall_req=0.
